// File: rtl/gpio_in_dev_pkg.sv
// Shared definitions for the switch/button input peripheral: default
// debounce depth, status-word field layout and the decoder base address.
package gpio_in_dev_pkg;

    // Defaults sized for a 50 MHz board clock (~10 ms debounce window).
    localparam int DB_CYCLES_DEF = 500000;
    localparam int CNT_W_DEF     = 19;

    localparam int N_SW  = 8;
    localparam int N_BTN = 4;
    localparam int N_IN  = N_SW + N_BTN;

    // Field offsets inside the 32-bit read word.
    localparam int SW_LSB   = 0;
    localparam int BTN_LSB  = 8;
    localparam int MASK_LSB = 12;
    localparam int PEND_LSB = 16;

    // Address the bus decoder matches to raise rd_en / we for this device.
    localparam logic [31:0] GPIO_IN_BASE = 32'hFFFF_FF04;

    // Assemble the status word; bits above the pending field read as zero.
    function automatic logic [31:0] pack_status(
        input logic [N_BTN-1:0] pend,
        input logic [N_BTN-1:0] msk,
        input logic [N_BTN-1:0] btn,
        input logic [N_SW-1:0]  sw
    );
        logic [31:0] w;
        w = '0;
        w[PEND_LSB +: N_BTN] = pend;
        w[MASK_LSB +: N_BTN] = msk;
        w[BTN_LSB  +: N_BTN] = btn;
        w[SW_LSB   +: N_SW]  = sw;
        return w;
    endfunction

endpackage

// File: rtl/gpio_in_dev_if.sv
// CPU-side peripheral bus for the input device: strobes and write data
// from the CPU, registered read word and interrupt back to it.
interface gpio_in_dev_if;

    logic        rd_en;
    logic        we;
    logic [31:0] wdata;
    logic [31:0] rd_data;
    logic        irq;

    modport master (
        output rd_en,
        output we,
        output wdata,
        input  rd_data,
        input  irq
    );

    modport slave (
        input  rd_en,
        input  we,
        input  wdata,
        output rd_data,
        output irq
    );

endinterface

// File: rtl/gpio_in_dev_debounce_bit.sv
// One input channel: two-flop synchronizer followed by a run-length
// debouncer. A new level is accepted only after DB_CYCLES consecutive
// falling edges of agreement; any return to the old level restarts the run.
module debounce_bit #(
    parameter int DB_CYCLES = 4,
    parameter int CNT_W     = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic stable,
    output logic rise
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DB_CYCLES - 1);

    logic             sync0;
    logic             sync1;
    logic [CNT_W-1:0] cnt;
    logic             stable_q;

    // Synchronize the raw level and count how long it has disagreed with the accepted level.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            sync0    <= 1'b0;
            sync1    <= 1'b0;
            cnt      <= '0;
            stable_q <= 1'b0;
        end else begin
            sync0 <= raw;
            sync1 <= sync0;
            if (sync1 == stable_q) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                stable_q <= sync1;
                cnt      <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    assign stable = stable_q;

    // High in the cycle whose falling edge will take the accepted level 0 -> 1,
    // so the owner can record the press on that same edge.
    assign rise = sync1 && !stable_q && (cnt == LAST);

endmodule

// File: rtl/gpio_in_dev.sv
// Memory-mapped switch/button input port. Debounces 8 switches and 4
// buttons, latches button presses into sticky pending bits that a read
// clears, and raises a level interrupt for unmasked pending presses.
// All state updates on the falling clock edge so the CPU can sample the
// read word on the following rising edge.
module gpio_in_dev
    import gpio_in_dev_pkg::*;
#(
    parameter int DB_CYCLES = DB_CYCLES_DEF,
    parameter int CNT_W     = CNT_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_SW-1:0]   sw_raw,
    input  logic [N_BTN-1:0]  btn_raw,
    gpio_in_dev_if.slave      bus,
    output logic [N_SW-1:0]   sw_stable
);

    logic [N_IN-1:0]  raw_all;
    logic [N_IN-1:0]  stable_all;
    logic [N_IN-1:0]  rise_all;
    logic [N_BTN-1:0] btn_stable;
    logic [N_BTN-1:0] btn_rise;
    logic [N_BTN-1:0] pending;
    logic [N_BTN-1:0] mask;
    logic [31:0]      rd_data_q;

    // Switches only need a level; their press strobes and the upper write bits are don't-care.
    logic sw_rise_unused;
    logic wdata_unused;

    assign raw_all = {btn_raw, sw_raw};

    genvar g;
    generate
        for (g = 0; g < N_IN; g++) begin : g_db
            debounce_bit #(
                .DB_CYCLES (DB_CYCLES),
                .CNT_W     (CNT_W)
            ) u_db (
                .clk    (clk),
                .rst    (rst),
                .raw    (raw_all[g]),
                .stable (stable_all[g]),
                .rise   (rise_all[g])
            );
        end
    endgenerate

    assign sw_stable      = stable_all[N_SW-1:0];
    assign btn_stable     = stable_all[N_IN-1:N_SW];
    assign btn_rise       = rise_all[N_IN-1:N_SW];
    assign sw_rise_unused = ^rise_all[N_SW-1:0];
    assign wdata_unused   = ^bus.wdata[31:N_BTN];

    // Read capture, pending set/clear (a new press beats the read clear) and mask write.
    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            pending   <= '0;
            mask      <= '0;
            rd_data_q <= '0;
        end else begin
            if (bus.rd_en) begin
                rd_data_q <= pack_status(pending, mask, btn_stable, sw_stable);
            end
            pending <= (bus.rd_en ? '0 : pending) | btn_rise;
            if (bus.we) begin
                mask <= bus.wdata[N_BTN-1:0];
            end
        end
    end

    assign bus.rd_data = rd_data_q;

    // Level interrupt straight from registers, so it only moves after a falling edge or reset.
    assign bus.irq = |(pending & mask);

endmodule
